// File: rtl/dma_priority_arbiter.sv
// DMA channel request arbiter: qualifies DREQ, grants one channel (fixed or rotating
// priority), drives DACK through the service cycle, tracks terminal count. Option: DREQ_SYNC_EN.
module dma_priority_arbiter #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic           dreqSenseLow,
  input  logic           rotatingPriority,
  input  logic [NCH-1:0] maskReg,
  input  logic [NCH-1:0] requestReg,
  input  logic           assertDACK,
  input  logic           intEOP,
  input  logic           statusRead,
  output logic [NCH-1:0] DACK,
  output logic           reqPending,
  output logic [1:0]     activeChannel,
  output logic           grantValid,
  output logic [NCH-1:0] tcStatus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t         state_r;
  logic [1:0]     last_served_r;
  logic [NCH-1:0] dreq_s;
  logic [NCH-1:0] eff_s;
  logic [1:0]     search_start_s;
  logic [1:0]     winner_s;
  logic [NCH-1:0] tc_set_s;
  logic [NCH-1:0] tc_next_s;

  // First requesting channel found when scanning upward from start, wrapping at 3.
  function automatic logic [1:0] pick_channel(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick_channel = start;
    found        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + k[1:0];
      if (!found && req[idx]) begin
        pick_channel = idx;
        found        = 1'b1;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [1:0] ch);
    onehot = {{(NCH-1){1'b0}}, 1'b1} << ch;
  endfunction

`ifdef DREQ_SYNC_EN
  logic [NCH-1:0] dreq_meta_r;
  logic [NCH-1:0] dreq_sync_r;

  // Two-flop synchronizer for asynchronous peripheral requests.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dreq_meta_r <= {NCH{1'b0}};
      dreq_sync_r <= {NCH{1'b0}};
    end else begin
      dreq_meta_r <= DREQ;
      dreq_sync_r <= dreq_meta_r;
    end
  end

  assign dreq_s = dreq_sync_r;
`else
  assign dreq_s = DREQ;
`endif

  // Request qualification and winner selection; software requests bypass the mask.
  always_comb begin
    eff_s = ((dreq_s ^ {NCH{dreqSenseLow}}) & ~maskReg) | requestReg;
    if (rotatingPriority) begin
      search_start_s = last_served_r + 2'd1;
    end else begin
      search_start_s = 2'd0;
    end
    winner_s = pick_channel(eff_s[3:0], search_start_s);
  end

  // Arbitration FSM; the grant stays locked from GRANT until assertDACK falls in SERVICE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r       <= IDLE;
      DACK          <= {NCH{1'b0}};
      reqPending    <= 1'b0;
      activeChannel <= 2'd0;
      grantValid    <= 1'b0;
      last_served_r <= 2'd3;
    end else begin
      reqPending <= |eff_s;
      case (state_r)
        IDLE: begin
          if (|eff_s) begin
            activeChannel <= winner_s;
            grantValid    <= 1'b1;
            state_r       <= GRANT;
          end
        end
        GRANT: begin
          if (assertDACK) begin
            DACK    <= onehot(activeChannel);
            state_r <= SERVICE;
          end
        end
        SERVICE: begin
          if (assertDACK) begin
            DACK <= onehot(activeChannel);
          end else begin
            DACK          <= {NCH{1'b0}};
            last_served_r <= activeChannel;
            grantValid    <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: begin
          DACK       <= {NCH{1'b0}};
          grantValid <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Terminal-count set takes precedence over a simultaneous status-read clear.
  always_comb begin
    if ((state_r == SERVICE) && intEOP) begin
      tc_set_s = onehot(activeChannel);
    end else begin
      tc_set_s = {NCH{1'b0}};
    end
    if (statusRead) begin
      tc_next_s = tc_set_s;
    end else begin
      tc_next_s = tcStatus | tc_set_s;
    end
  end

  // Sticky terminal-count register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tcStatus <= {NCH{1'b0}};
    end else begin
      tcStatus <= tc_next_s;
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter (default build, no DREQ synchronizer).
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       dreqSenseLow;
  logic       rotatingPriority;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic       assertDACK;
  logic       intEOP;
  logic       statusRead;
  logic [3:0] DACK;
  logic       reqPending;
  logic [1:0] activeChannel;
  logic       grantValid;
  logic [3:0] tcStatus;

  int n_checks = 0;
  int n_fail   = 0;

  dma_priority_arbiter #(.NCH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .dreqSenseLow(dreqSenseLow),
    .rotatingPriority(rotatingPriority), .maskReg(maskReg), .requestReg(requestReg),
    .assertDACK(assertDACK), .intEOP(intEOP), .statusRead(statusRead), .DACK(DACK),
    .reqPending(reqPending), .activeChannel(activeChannel), .grantValid(grantValid),
    .tcStatus(tcStatus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; DREQ = 4'b0000; dreqSenseLow = 1'b0; rotatingPriority = 1'b0;
    maskReg = 4'b0000; requestReg = 4'b0000; assertDACK = 1'b0; intEOP = 1'b0; statusRead = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    tick();
    n_checks++;
    if ({DACK, reqPending, activeChannel, grantValid, tcStatus} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got DACK=%b rp=%b ch=%0d gv=%b tc=%b, want all zero",
               DACK, reqPending, activeChannel, grantValid, tcStatus);
    end
  endtask

  task automatic test_fixed_priority();
    DREQ = 4'b1010;
    tick();
    n_checks++;
    if (reqPending !== 1'b1 || grantValid !== 1'b1 || activeChannel !== 2'd1) begin
      n_fail++;
      $display("FAIL fixed_grant: got rp=%b gv=%b ch=%0d, want rp=1 gv=1 ch=1",
               reqPending, grantValid, activeChannel);
    end
    assertDACK = 1'b1;
    tick();
    n_checks++;
    if (DACK !== 4'b0010) begin
      n_fail++;
      $display("FAIL fixed_dack_first: got %b want 0010", DACK);
    end
    tick();
    n_checks++;
    if (DACK !== 4'b0010) begin
      n_fail++;
      $display("FAIL fixed_dack_hold: got %b want 0010", DACK);
    end
    assertDACK = 1'b0; DREQ = 4'b0000;
    tick();
    n_checks++;
    if (DACK !== 4'b0000 || grantValid !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_release: got DACK=%b gv=%b want DACK=0000 gv=0", DACK, grantValid);
    end
    tick();
    n_checks++;
    if (grantValid !== 1'b0 || reqPending !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_idle: got gv=%b rp=%b want 0 0", grantValid, reqPending);
    end
  endtask

  task automatic test_rotating();
    logic [1:0] exp_ch [5];
    logic [3:0] exp_dack;
    exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd3; exp_ch[4] = 2'd0;
    RESET = 1'b1; tick(); RESET = 1'b0;
    rotatingPriority = 1'b1; DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (grantValid !== 1'b1 || activeChannel !== exp_ch[i]) begin
        n_fail++;
        $display("FAIL rotate_grant%0d: got gv=%b ch=%0d want gv=1 ch=%0d",
                 i, grantValid, activeChannel, exp_ch[i]);
      end
      assertDACK = 1'b1;
      tick();
      exp_dack = 4'b0001 << exp_ch[i];
      n_checks++;
      if (DACK !== exp_dack) begin
        n_fail++;
        $display("FAIL rotate_dack%0d: got %b want %b", i, DACK, exp_dack);
      end
      assertDACK = 1'b0;
      tick();
    end
    DREQ = 4'b0000; rotatingPriority = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    maskReg = 4'b0001; DREQ = 4'b0001; requestReg = 4'b0000;
    tick(); tick();
    n_checks++;
    if (reqPending !== 1'b0 || grantValid !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_block: got rp=%b gv=%b want 0 0", reqPending, grantValid);
    end
    requestReg = 4'b0001;
    tick();
    n_checks++;
    if (reqPending !== 1'b1 || grantValid !== 1'b1 || activeChannel !== 2'd0) begin
      n_fail++;
      $display("FAIL mask_swreq: got rp=%b gv=%b ch=%0d want 1 1 0",
               reqPending, grantValid, activeChannel);
    end
    requestReg = 4'b0000;
    tick();
    n_checks++;
    if (grantValid !== 1'b1 || activeChannel !== 2'd0) begin
      n_fail++;
      $display("FAIL grant_locked: got gv=%b ch=%0d want 1 0", grantValid, activeChannel);
    end
    assertDACK = 1'b1; tick(); assertDACK = 1'b0; tick();
    maskReg = 4'b0000; DREQ = 4'b0000;
    tick();
  endtask

  task automatic test_tc_status();
    DREQ = 4'b1000;
    tick();
    intEOP = 1'b1;
    tick();
    intEOP = 1'b0;
    n_checks++;
    if (tcStatus !== 4'b0000) begin
      n_fail++;
      $display("FAIL tc_outside_service: got %b want 0000", tcStatus);
    end
    assertDACK = 1'b1; tick();
    intEOP = 1'b1; tick(); intEOP = 1'b0;
    n_checks++;
    if (tcStatus !== 4'b1000) begin
      n_fail++;
      $display("FAIL tc_set_ch3: got %b want 1000", tcStatus);
    end
    assertDACK = 1'b0; DREQ = 4'b0100; tick();
    tick();
    assertDACK = 1'b1; tick();
    intEOP = 1'b1; statusRead = 1'b1; tick(); intEOP = 1'b0; statusRead = 1'b0;
    n_checks++;
    if (tcStatus !== 4'b0100) begin
      n_fail++;
      $display("FAIL tc_set_wins: got %b want 0100", tcStatus);
    end
    assertDACK = 1'b0; DREQ = 4'b0000; tick();
    statusRead = 1'b1; tick(); statusRead = 1'b0;
    n_checks++;
    if (tcStatus !== 4'b0000) begin
      n_fail++;
      $display("FAIL tc_clear: got %b want 0000", tcStatus);
    end
  endtask

  task automatic test_sense_low_and_reset();
    dreqSenseLow = 1'b1; DREQ = 4'b1011;
    tick();
    n_checks++;
    if (grantValid !== 1'b1 || activeChannel !== 2'd2) begin
      n_fail++;
      $display("FAIL sense_low_grant: got gv=%b ch=%0d want 1 2", grantValid, activeChannel);
    end
    assertDACK = 1'b1; tick();
    n_checks++;
    if (DACK !== 4'b0100) begin
      n_fail++;
      $display("FAIL sense_low_dack: got %b want 0100", DACK);
    end
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if (DACK !== 4'b0000 || grantValid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_dack: got DACK=%b gv=%b want 0000 0", DACK, grantValid);
    end
    assertDACK = 1'b0; dreqSenseLow = 1'b0; rotatingPriority = 1'b1; DREQ = 4'b1111;
    tick();
    RESET = 1'b0;
    tick();
    n_checks++;
    if (grantValid !== 1'b1 || activeChannel !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_rotate: got gv=%b ch=%0d want 1 0", grantValid, activeChannel);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rotating();
    test_mask();
    test_tc_status();
    test_sense_low_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
